// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word-addressed memory: independent read and write FSMs,
// FIXED/INCR bursts, full-width beats with byte strobes, SLVERR on illegal or out-of-range beats.
module axi_slave_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                  aclk,
    input  logic                  arst,

    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,

    output logic [1:0]            w_state_dbg,
    output logic                  r_state_dbg
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LSB    = $clog2(BYTES);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0]     ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0]     STEP       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-LSB-1:0] DEPTH_W    = (ADDR_W - LSB)'(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_W-1:0] mem [DEPTH];

    // Low until the first edge after reset release, so both address channels
    // stay closed while arst is high and open exactly one edge later.
    logic rst_done;

    // Handshake rule for every channel: a transfer happens only at a rising
    // aclk edge where the channel's valid and ready are both high.
    logic aw_hs, w_hs, ar_hs, r_hs;

    function automatic logic beat_legal(input logic [1:0] burst, input logic [ADDR_W-1:0] addr);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (addr[ADDR_W-1:LSB] < DEPTH_W);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[LSB +: MEM_AW];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [1:0] burst, input logic [ADDR_W-1:0] addr);
        return (burst == BURST_INCR) ? addr + STEP : addr;
    endfunction

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) rst_done <= 1'b0;
        else      rst_done <= 1'b1;
    end

    // ------------------------------------------------------------------ write
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [1:0]        w_burst;
    logic              w_err;
    logic [1:0]        bresp_q;
    logic              w_legal, w_last_beat, w_beat_err;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = rst_done;
                if (awvalid && rst_done) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        w_legal     = beat_legal(w_burst, w_addr);
        w_last_beat = (w_cnt == w_len);
        // A misplaced wlast only flags the error; the burst length comes from awlen.
        w_beat_err  = !w_legal || (wlast != w_last_beat);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr & ALIGN_MASK;
            w_len   <= awlen;
            w_cnt   <= '0;
            w_burst <= awburst;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_burst, w_addr);
            w_err  <= w_err || w_beat_err;
            if (w_last_beat) bresp_q <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && w_legal) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign bid   = w_id;
    assign bresp = bresp_q;

    // ------------------------------------------------------------------- read
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [1:0]        r_burst;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [1:0]        r_fetch_burst;
    logic              r_fetch_legal;
    logic [DATA_W-1:0] r_fetch_data;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = rst_done;
                if (arvalid && rst_done) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_next = R_IDLE;
            end
        endcase
    end

    // The beat to present next: the first beat on AR, else the successor of the current one.
    always_comb begin
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (ar_hs) begin
            r_fetch_addr  = araddr & ALIGN_MASK;
            r_fetch_burst = arburst;
        end else begin
            r_fetch_addr  = next_addr(r_burst, r_addr);
            r_fetch_burst = r_burst;
        end
        r_fetch_legal = beat_legal(r_fetch_burst, r_fetch_addr);
        r_fetch_data  = r_fetch_legal ? mem[word_idx(r_fetch_addr)] : '0;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= arid;
            r_addr  <= r_fetch_addr;
            r_len   <= arlen;
            r_cnt   <= '0;
            r_burst <= arburst;
            rdata   <= r_fetch_data;
            rresp   <= r_fetch_legal ? RESP_OKAY : RESP_SLVERR;
            rlast   <= (arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                r_addr <= r_fetch_addr;
                r_cnt  <= r_cnt + 8'd1;
                rdata  <= r_fetch_data;
                rresp  <= r_fetch_legal ? RESP_OKAY : RESP_SLVERR;
                rlast  <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

    assign rid         = r_id;
    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: randomized bursts scored against a word-array memory model,
// directed corner cases and a mid-burst reset.
module tb_axi_slave_mem;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 256;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic              aclk, arst;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wvalid, wready, wlast;
  logic              bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        w_state_dbg;
  logic              r_state_dbg;

  axi_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected responses: B = {id, resp}; R = {id, data, resp, last}
  logic [ID_W+1:0]        exp_b_q[$];
  logic [ID_W+DATA_W+2:0] exp_r_q[$];
  logic [DATA_W-1:0]      ref_mem[DEPTH];
  logic [DATA_W-1:0]      wd_q[$];
  logic [3:0]             ws_q[$];

  int rready_mode  = 0;
  int b_hold       = 0;
  int b_stall      = 0;
  int last_b_stall = 0;
  int cyc          = 0;
  int aw_hs_cyc    = -1;
  int ar_hs_cyc    = -2;

  // ---------------------------------------------------------- clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------ response drivers
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (rready_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'b0;
      endcase
    end
  end

  initial begin
    bready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bready = (b_hold == 0);
      if (b_hold > 0 && bvalid) b_hold--;
    end
  end

  // --------------------------------------------------------------- monitor
  initial forever begin
    logic [ID_W+1:0]        eb;
    logic [ID_W+DATA_W+2:0] er;
    @(negedge aclk);
    if (!arst) begin
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected_bvalid", bvalid, 1'b0);
        else begin
          eb = exp_b_q.pop_front();
          check("bid", bid, eb[ID_W+1:2]);
          check("bresp", bresp, eb[1:0]);
        end
        last_b_stall = b_stall;
        b_stall = 0;
      end else if (bvalid) begin
        b_stall++;
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) check("r_unexpected_rvalid", rvalid, 1'b0);
        else begin
          er = exp_r_q.pop_front();
          check("rid", rid, er[ID_W+DATA_W+2:DATA_W+3]);
          check("rdata", rdata, er[DATA_W+2:3]);
          check("rresp", rresp, er[2:1]);
          check("rlast", rlast, er[0]);
        end
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    do begin @(negedge aclk); t++; end while (!awready && t < 500);
    check("aw_handshake", awready, 1'b1);
    aw_hs_cyc = cyc;
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    do begin @(negedge aclk); t++; end while (!arready && t < 500);
    check("ar_handshake", arready, 1'b1);
    ar_hs_cyc = cyc;
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [3:0] s, input logic l);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    do begin @(negedge aclk); t++; end while (!wready && t < 500);
    check("w_handshake", wready, 1'b1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  // Beat data comes from wd_q/ws_q; bad_beat flips wlast on that beat (-1 = none).
  task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int len, input logic [1:0] burst, input int bad_beat);
    logic [DATA_W-1:0] d [256];
    logic [3:0]        s [256];
    logic              l [256];
    longint unsigned   base, idx;
    bit                err;
    err  = 0;
    base = {32'b0, addr} >> 2;
    for (int i = 0; i <= len; i++) begin
      d[i] = wd_q.pop_front();
      s[i] = ws_q.pop_front();
      l[i] = (i == len) ^ (i == bad_beat);
      idx  = base + ((burst == INCR) ? i : 0);
      if (burst > INCR || idx >= DEPTH) err = 1;
      else for (int b = 0; b < 4; b++) if (s[i][b]) ref_mem[idx][8*b +: 8] = d[i][8*b +: 8];
      if (l[i] != (i == len)) err = 1;
    end
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
    send_aw(id, addr, 8'(len), burst);
    for (int i = 0; i <= len; i++) send_w(d[i], s[i], l[i]);
  endtask

  task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst);
    longint unsigned base, idx;
    bit              legal;
    base = {32'b0, addr} >> 2;
    for (int i = 0; i <= len; i++) begin
      idx   = base + ((burst == INCR) ? i : 0);
      legal = (burst <= INCR) && (idx < DEPTH);
      exp_r_q.push_back({id, legal ? ref_mem[idx] : 32'h0, legal ? 2'b00 : 2'b10, i == len});
    end
    send_ar(id, addr, 8'(len), burst);
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic [3:0] s);
    wd_q.push_back(d);
    ws_q.push_back(s);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 4000) begin
      @(negedge aclk); t++;
    end
    check("drain_b", exp_b_q.size(), 0);
    check("drain_r", exp_r_q.size(), 0);
    @(posedge aclk); #1;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    arst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready",  wready,  1'b0);
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_rlast",   rlast,   1'b0);
    check("rst_bresp",   bresp,   2'b00);
    check("rst_rresp",   rresp,   2'b00);
    check("rst_bid",     bid,     '0);
    check("rst_rid",     rid,     '0);
    check("rst_rdata",   rdata,   '0);
    @(negedge aclk);
    arst = 1'b0;
    #1;
    check("awready_before_edge", awready, 1'b0);
    @(posedge aclk); #1;
    check("awready_after_rst", awready, 1'b1);
    check("arready_after_rst", arready, 1'b1);

    // Fill every word so later reads compare against known contents
    for (int i = 0; i < DEPTH; i++) push_beat($urandom, 4'hF);
    axi_write(4'h1, 32'h0, DEPTH - 1, INCR, -1);
    wait_idle();

    // Single write / read
    push_beat(32'hDEADBEEF, 4'hF);
    axi_write(4'h2, 32'h10, 0, INCR, -1);
    axi_read(4'h3, 32'h10, 0, INCR);
    wait_idle();

    // INCR burst read back with rready toggling
    for (int i = 1; i <= 4; i++) push_beat(32'(i), 4'hF);
    axi_write(4'h4, 32'h0, 3, INCR, -1);
    rready_mode = 1;
    axi_read(4'h5, 32'h0, 3, INCR);
    wait_idle();
    rready_mode = 0;

    // Partial strobes
    push_beat(32'h11223344, 4'hF);
    axi_write(4'h6, 32'h20, 0, INCR, -1);
    push_beat(32'hAABBCCDD, 4'b0101);
    axi_write(4'h6, 32'h20, 0, INCR, -1);
    axi_read(4'h7, 32'h20, 0, INCR);
    wait_idle();

    // End of memory, illegal bursts, FIXED, wlast errors
    push_beat(32'hCAFE0001, 4'hF);
    push_beat(32'hCAFE0002, 4'hF);
    axi_write(4'h8, 32'((DEPTH - 1) * 4), 1, INCR, -1);
    axi_read(4'h9, 32'((DEPTH - 1) * 4), 0, INCR);
    axi_read(4'h9, 32'h0, 0, INCR);
    axi_read(4'hA, 32'h0, 3, WRAP);
    wait_idle();
    push_beat(32'h55555555, 4'hF);
    axi_write(4'hB, 32'h30, 0, RSVD, -1);
    for (int i = 0; i < 3; i++) push_beat(32'h7000_0000 + 32'(i), 4'hF);
    axi_write(4'hC, 32'h34, 2, FIXED, -1);
    axi_read(4'hD, 32'h30, 1, INCR);
    axi_read(4'hD, 32'h34, 2, FIXED);
    wait_idle();
    for (int i = 0; i < 3; i++) push_beat(32'h8000_0000 + 32'(i), 4'hF);
    axi_write(4'hE, 32'h40, 2, INCR, 1);
    push_beat(32'h9999_0000, 4'hF);
    axi_write(4'hE, 32'h50, 0, INCR, 0);
    axi_read(4'hF, 32'h40, 4, INCR);
    axi_read(4'hF, 32'((DEPTH - 2) * 4), 3, INCR);
    wait_idle();

    // Concurrent AW and AR, B held off for 5 cycles
    push_beat(32'h1234_0001, 4'hF);
    push_beat(32'h1234_0002, 4'hF);
    b_hold = 5;
    fork
      axi_write(4'h3, 32'h100, 1, INCR, -1);
      axi_read(4'h5, 32'h200, 2, INCR);
    join
    wait_idle();
    check("aw_ar_same_cycle", ar_hs_cyc, aw_hs_cyc);
    check("bvalid_stall_cycles", last_b_stall, 5);

    // Randomized write-then-read pairs
    for (int t = 0; t < 30; t++) begin
      logic [1:0]        br;
      logic [ADDR_W-1:0] a;
      int                len, bad, r;
      r   = $urandom_range(0, 9);
      br  = (r < 5) ? INCR : (r < 8) ? FIXED : (r == 8) ? WRAP : RSVD;
      len = $urandom_range(0, 7);
      a   = 32'($urandom_range(0, (DEPTH + 2) * 4 - 1));
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      for (int i = 0; i <= len; i++) push_beat($urandom, 4'($urandom_range(0, 15)));
      b_hold = $urandom_range(0, 3);
      axi_write(4'($urandom_range(0, 15)), a, len, br, bad);
      rready_mode = $urandom_range(0, 1);
      axi_read(4'($urandom_range(0, 15)), a, len, br);
      wait_idle();
      rready_mode = 0;
    end

    // Reset in the middle of a write burst with a stalled read outstanding
    rready_mode = 2;
    @(posedge aclk); #1;
    send_ar(4'h2, 32'h0, 3, INCR);
    send_aw(4'h4, 32'h0, 3, INCR);
    send_w(32'hA0A0_0001, 4'hF, 1'b0);
    ref_mem[0] = 32'hA0A0_0001;
    send_w(32'hA0A0_0002, 4'hF, 1'b0);
    ref_mem[1] = 32'hA0A0_0002;
    check("rvalid_stalled_before_rst", rvalid, 1'b1);
    #3 arst = 1'b1;
    #1;
    check("midrst_awready", awready, 1'b0);
    check("midrst_arready", arready, 1'b0);
    check("midrst_wready",  wready,  1'b0);
    check("midrst_bvalid",  bvalid,  1'b0);
    check("midrst_rvalid",  rvalid,  1'b0);
    check("midrst_rlast",   rlast,   1'b0);
    check("midrst_rdata",   rdata,   '0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arst = 1'b0;
    rready_mode = 0;
    #1;
    check("midrst_awready_pre_edge", awready, 1'b0);
    @(posedge aclk); #1;
    check("midrst_awready_post", awready, 1'b1);
    check("midrst_arready_post", arready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("no_stale_bvalid", bvalid, 1'b0);
      check("no_stale_rvalid", rvalid, 1'b0);
    end
    @(posedge aclk); #1;
    axi_read(4'h6, 32'h0, 3, INCR);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; fixed full-width transfers (4 bytes per beat at default).
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter DEPTH, default 256, memory depth in DATA_W words.
REQ-005 SHALL have port aclk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port arst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports awid/awaddr/awlen/awburst, input, ID_W/ADDR_W/8/2, write address channel payload.
REQ-008 SHALL have ports awvalid (input, 1) and awready (output, 1), AW handshake.
REQ-009 SHALL have ports wdata/wstrb/wlast, input, DATA_W/DATA_W/8/1, write data payload.
REQ-010 SHALL have ports wvalid (input, 1) and wready (output, 1), W handshake.
REQ-011 SHALL have ports bid/bresp, output, ID_W/2, write response payload.
REQ-012 SHALL have ports bvalid (output, 1) and bready (input, 1), B handshake.
REQ-013 SHALL have ports arid/araddr/arlen/arburst, input, ID_W/ADDR_W/8/2, read address payload.
REQ-014 SHALL have ports arvalid (input, 1) and arready (output, 1), AR handshake.
REQ-015 SHALL have ports rid/rdata/rresp/rlast, output, ID_W/DATA_W/2/1, read data payload.
REQ-016 SHALL have ports rvalid (output, 1) and rready (input, 1), R handshake.

Function
REQ-017 SHALL transfer on any channel only in a cycle where valid and ready are both high at the aclk rising edge.
REQ-018 SHALL implement the write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-019 SHALL, on an AW handshake, latch awid, word-aligned awaddr (low log2(DATA_W/8) bits cleared), awlen and awburst, clear the beat counter and error flag, and enter W_DATA on the next cycle.
REQ-020 SHALL, on each W handshake with a legal beat, write byte lanes whose wstrb bit is 1 to the addressed word; lanes with wstrb 0 stay unchanged.
REQ-021 SHALL advance the beat address by DATA_W/8 for INCR (burst 01) and hold it for FIXED (burst 00).
REQ-022 SHALL treat WRAP (10) and reserved (11) bursts as illegal: writes suppressed, every read beat errored.
REQ-023 SHALL treat a beat whose word index is >= DEPTH as out of range: write suppressed, read rdata 0, error set.
REQ-024 SHALL set the write error flag when wlast mismatches (beat count == awlen); a wlast mismatch does not terminate the burst.
REQ-025 SHALL enter W_RESP after beat number awlen (awlen+1 beats); bid = latched awid; bresp = 2'b10 (SLVERR) if any error, else 2'b00.
REQ-026 SHALL hold bvalid, bid and bresp stable until bready, then return to W_IDLE.
REQ-027 SHALL implement the read FSM R_IDLE -> R_DATA -> R_IDLE; arready=1 only in R_IDLE.
REQ-028 SHALL, on an AR handshake, latch arid, aligned araddr, arlen and arburst, load the first beat into registered rdata/rresp, and assert rvalid the next cycle (1-cycle latency).
REQ-029 SHALL hold rdata/rresp/rlast stable while rvalid=1 and rready=0.
REQ-030 SHALL, on each R handshake, load the next beat; rlast=1 exactly on beat arlen; after the rlast handshake, return to R_IDLE with rvalid=0.
REQ-031 SHALL run the read and write FSMs independently and concurrently; a read beat loaded on the same edge as a write to that word returns the pre-write data.
REQ-032 SHALL, for an INCR burst crossing the end of memory, return OKAY for in-range beats and SLVERR for the rest.

Reset
REQ-033 SHALL, while arst=1 (asynchronously), force both FSMs to idle, awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0; awready and arready rise to 1 on the first aclk edge after arst deasserts; memory contents are not reset.
REQ-034 SHALL abandon any in-flight burst on arst assertion; no partial response is issued afterwards.

Verification
REQ-035 Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, then read araddr=0x10 -> bresp=00, rdata=0xDEADBEEF, rlast=1, rresp=00.
REQ-036 INCR write awlen=3 at 0x0, data 1..4, with rready toggled every cycle on readback -> four beats 1,2,3,4, rlast only on the 4th, data stable under stall.
REQ-037 Partial strobe: word 0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> readback 0x11BB33DD.
REQ-038 Out-of-range/illegal: INCR awlen=1 at word DEPTH-1 -> bresp=10, word DEPTH-1 written, no wraparound write; WRAP burst read -> all rresp=10.
REQ-039 Concurrent AW and AR in the same cycle at different addresses with bready held low 5 cycles -> both handshakes accepted, bvalid held 5 cycles, read completes unaffected.
REQ-040 arst asserted mid-burst (beat 2 of 4) -> all valids 0 immediately; awready=arready=1 one edge after release; no stale bvalid/rvalid.
